// File: rtl/efb_wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the EFB:
// arbiter state encoding, config-register constants and a grant helper.
package efb_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

    localparam logic [7:0] CFGCR_ADR  = 8'h70;
    localparam int         CFG_EN_BIT = 7;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/efb_wb_arbiter.sv
// Two-master Wishbone classic arbiter for the EFB port. A master that opens a
// config frame keeps the bus locked between cycles until it closes or times out.
module efb_wb_arbiter
    import efb_wb_arbiter_pkg::*;
#(
    parameter int ACK_TIMEOUT  = 64,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       m0_cyc_i,
    input  logic       m0_stb_i,
    input  logic       m0_we_i,
    input  logic [7:0] m0_adr_i,
    input  logic [7:0] m0_dat_i,
    output logic [7:0] m0_dat_o,
    output logic       m0_ack_o,
    output logic       m0_err_o,

    input  logic       m1_cyc_i,
    input  logic       m1_stb_i,
    input  logic       m1_we_i,
    input  logic [7:0] m1_adr_i,
    input  logic [7:0] m1_dat_i,
    output logic [7:0] m1_dat_o,
    output logic       m1_ack_o,
    output logic       m1_err_o,

    output logic       efb_cyc_o,
    output logic       efb_stb_o,
    output logic       efb_we_o,
    output logic [7:0] efb_adr_o,
    output logic [7:0] efb_dat_o,
    input  logic [7:0] efb_dat_i,
    input  logic       efb_ack_i,

    output logic [1:0] grant,
    output logic       lock_timeout
);

    localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              frame_q, frame_d;
    logic              lock_q, lock_d;
    logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic       own_cyc;
    logic       own_stb;
    logic       own_we;
    logic [7:0] own_adr;
    logic [7:0] own_dat;
    logic       busy;
    logic       bus_ack;
    logic       ack_to;
    logic       cfg_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            frame_q    <= 1'b0;
            lock_q     <= 1'b0;
            ack_cnt_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            frame_q    <= frame_d;
            lock_q     <= lock_d;
            ack_cnt_q  <= ack_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
        own_stb = owner_q ? m1_stb_i : m0_stb_i;
        own_we  = owner_q ? m1_we_i  : m0_we_i;
        own_adr = owner_q ? m1_adr_i : m0_adr_i;
        own_dat = owner_q ? m1_dat_i : m0_dat_i;
        busy    = (state_q == ST_BUSY);
        bus_ack = busy && own_stb && efb_ack_i;
        // An ack arriving on the last allowed cycle still wins over the timeout.
        ack_to  = busy && own_stb && !efb_ack_i && (ack_cnt_q == ACK_LAST);
        cfg_wr  = bus_ack && own_we && (own_adr == CFGCR_ADR);
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        frame_d    = frame_q;
        lock_d     = 1'b0;
        ack_cnt_d  = '0;
        hold_cnt_d = '0;

        if (cfg_wr) begin
            frame_d = own_dat[CFG_EN_BIT];
        end

        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_d = ST_BUSY;
                    owner_d = (m0_cyc_i && m1_cyc_i) ? !last_q : m1_cyc_i;
                    last_d  = owner_d;
                end
            end
            ST_BUSY: begin
                // frame_d already reflects a close write landing in this same cycle.
                if (!own_cyc) begin
                    state_d = frame_d ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (own_cyc) begin
                    state_d = ST_BUSY;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    frame_d = 1'b0;
                    lock_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                frame_d = 1'b0;
            end
        endcase

        if (busy && own_stb && !efb_ack_i && !ack_to && (ack_cnt_q != '1)) begin
            ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end else if (busy && own_stb && !efb_ack_i && !ack_to) begin
            ack_cnt_d = ack_cnt_q;
        end

        if (state_q == ST_HOLD && state_d == ST_HOLD) begin
            hold_cnt_d = (hold_cnt_q != '1) ? hold_cnt_q + HOLD_W'(1) : hold_cnt_q;
        end
    end

    always_comb begin
        grant        = (state_q == ST_IDLE) ? 2'b00 : owner_onehot(owner_q);
        lock_timeout = lock_q;

        m0_dat_o = efb_dat_i;
        m1_dat_o = efb_dat_i;
        m0_ack_o = efb_ack_i && grant[0] && m0_stb_i;
        m1_ack_o = efb_ack_i && grant[1] && m1_stb_i;
        m0_err_o = ack_to && !owner_q;
        m1_err_o = ack_to && owner_q;

        efb_cyc_o = 1'b0;
        efb_stb_o = 1'b0;
        efb_we_o  = 1'b0;
        efb_adr_o = 8'h00;
        efb_dat_o = 8'h00;
        if (busy) begin
            efb_cyc_o = own_cyc;
            efb_stb_o = own_stb && !ack_to;
            efb_we_o  = own_we;
            efb_adr_o = own_adr;
            efb_dat_o = own_dat;
        end
    end

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Directed bench for efb_wb_arbiter: single writes, arbitration order, config-frame
// lock, both watchdogs and reset in the middle of a transfer.
module tb_efb_wb_arbiter;

    localparam int AT = 8;
    localparam int HT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [7:0] m0_adr_i = 0, m0_dat_i = 0;
    logic       m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [7:0] m1_adr_i = 0, m1_dat_i = 0;
    logic [7:0] m0_dat_o, m1_dat_o;
    logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic       efb_cyc_o, efb_stb_o, efb_we_o;
    logic [7:0] efb_adr_o, efb_dat_o;
    logic [7:0] efb_dat_i = 0;
    logic       efb_ack_i = 0;
    logic [1:0] grant;
    logic       lock_timeout;

    int errors = 0;
    int checks = 0;

    efb_wb_arbiter #(.ACK_TIMEOUT(AT), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .efb_cyc_o(efb_cyc_o), .efb_stb_o(efb_stb_o), .efb_we_o(efb_we_o),
        .efb_adr_o(efb_adr_o), .efb_dat_o(efb_dat_o), .efb_dat_i(efb_dat_i),
        .efb_ack_i(efb_ack_i), .grant(grant), .lock_timeout(lock_timeout)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0;
        efb_ack_i = 0;
    endtask

    task automatic m0_write(input logic [7:0] adr, input logic [7:0] dat);
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = adr; m0_dat_i = dat;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (lock_timeout !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b want 0", lock_timeout); end
        checks++; if ({efb_cyc_o, efb_stb_o, efb_we_o} !== 3'b000) begin errors++; $display("FAIL reset_efb: got %b want 000", {efb_cyc_o, efb_stb_o, efb_we_o}); end
    endtask

    task automatic test_single_write();
        step();
        m0_write(8'h70, 8'h80);
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sw_grant_pre: got %b want 00", grant); end
        step();
        #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sw_grant: got %b want 01", grant); end
        checks++; if (efb_dat_o !== 8'h80 || efb_adr_o !== 8'h70 || efb_stb_o !== 1'b1) begin errors++; $display("FAIL sw_efb_bus: got adr %h dat %h stb %b want 70 80 1", efb_adr_o, efb_dat_o, efb_stb_o); end
        checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL sw_ack_early: got %b want 0", m0_ack_o); end
        step();
        efb_ack_i = 1; efb_dat_i = 8'h5a;
        #1;
        checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin errors++; $display("FAIL sw_ack: got m0 %b m1 %b want 1 0", m0_ack_o, m1_ack_o); end
        checks++; if (m0_dat_o !== 8'h5a || m1_dat_o !== 8'h5a) begin errors++; $display("FAIL sw_rdata: got %h %h want 5a 5a", m0_dat_o, m1_dat_o); end
        step();
        clear_inputs();
        #1;
        checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL sw_ack_once: got %b want 0", m0_ack_o); end
        step();
        #1;
        checks++; if (grant !== 2'b01 || efb_cyc_o !== 1'b0) begin errors++; $display("FAIL sw_hold: got grant %b cyc %b want 01 0", grant, efb_cyc_o); end
        m0_write(8'h70, 8'h00);
        step();
        #1;
        checks++; if (efb_cyc_o !== 1'b1) begin errors++; $display("FAIL sw_resume: got %b want 1", efb_cyc_o); end
        efb_ack_i = 1;
        step();
        clear_inputs();
        step();
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sw_closed: got %b want 00", grant); end
    endtask

    task automatic test_arbitration();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
        m0_cyc_i = 1; m1_cyc_i = 1;
        step();
        #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL arb_first: got %b want 01", grant); end
        m0_cyc_i = 0;
        step();
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arb_idle_gap: got %b want 00", grant); end
        step();
        #1;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL arb_second: got %b want 10", grant); end
        m1_cyc_i = 0;
        step();
        m0_cyc_i = 1; m1_cyc_i = 1;
        step();
        #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL arb_rotate: got %b want 01", grant); end
        clear_inputs();
        step();
        step();
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arb_release: got %b want 00", grant); end
    endtask

    task automatic test_frame_hold();
        m0_write(8'h70, 8'h80);
        step();
        efb_ack_i = 1;
        #1;
        checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL fr_open_ack: got %b want 1", m0_ack_o); end
        step();
        clear_inputs();
        m1_cyc_i = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            checks++; if (grant !== 2'b01 || efb_cyc_o !== 1'b0) begin errors++; $display("FAIL fr_hold_%0d: got grant %b cyc %b want 01 0", i, grant, efb_cyc_o); end
        end
        m0_write(8'h70, 8'h00);
        step();
        #1;
        checks++; if (grant !== 2'b01 || efb_cyc_o !== 1'b1) begin errors++; $display("FAIL fr_return: got grant %b cyc %b want 01 1", grant, efb_cyc_o); end
        // Close write acked in the same cycle the owner drops cyc.
        m0_cyc_i = 0;
        efb_ack_i = 1;
        #1;
        checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL fr_close_ack: got %b want 1", m0_ack_o); end
        step();
        m0_stb_i = 0; m0_we_i = 0; efb_ack_i = 0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fr_close_idle: got %b want 00", grant); end
        step();
        #1;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL fr_m1_grant: got %b want 10", grant); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_ack_timeout();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 8'h10;
        for (int c = 1; c <= AT + 1; c++) begin
            step();
            #1;
            checks++; if (m0_err_o !== (c == AT) || efb_stb_o !== (c != AT)) begin errors++; $display("FAIL ato_cycle_%0d: got err %b stb %b want %b %b", c, m0_err_o, efb_stb_o, c == AT, c != AT); end
            checks++; if (m1_err_o !== 1'b0) begin errors++; $display("FAIL ato_m1_err_%0d: got %b want 0", c, m1_err_o); end
        end
        m0_stb_i = 0;
        step();
        m0_stb_i = 1;
        for (int c = 1; c <= AT + 4; c++) begin
            step();
            efb_ack_i = (c == 4);
            #1;
            if (c == 4) begin
                checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL ato_mid_ack: got %b want 1", m0_ack_o); end
            end
            checks++; if (m0_err_o !== (c == AT + 4)) begin errors++; $display("FAIL ato_after_ack_%0d: got %b want %b", c, m0_err_o, c == AT + 4); end
        end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_hold_timeout();
        m0_write(8'h70, 8'h80);
        step();
        efb_ack_i = 1;
        step();
        clear_inputs();
        m1_cyc_i = 1;
        for (int h = 1; h <= HT; h++) begin
            step();
            #1;
            checks++; if (lock_timeout !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL hto_hold_%0d: got lock %b grant %b want 0 01", h, lock_timeout, grant); end
        end
        step();
        #1;
        checks++; if (lock_timeout !== 1'b1 || grant !== 2'b00) begin errors++; $display("FAIL hto_pulse: got lock %b grant %b want 1 00", lock_timeout, grant); end
        step();
        #1;
        checks++; if (lock_timeout !== 1'b0 || grant !== 2'b10) begin errors++; $display("FAIL hto_m1: got lock %b grant %b want 0 10", lock_timeout, grant); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        step();
        #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_pre_grant: got %b want 01", grant); end
        efb_ack_i = 1;
        rst = 1;
        step();
        rst = 0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
        checks++; if ({efb_cyc_o, efb_stb_o, efb_we_o} !== 3'b000) begin errors++; $display("FAIL rst_efb: got %b want 000", {efb_cyc_o, efb_stb_o, efb_we_o}); end
        checks++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin errors++; $display("FAIL rst_term: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
        clear_inputs();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_arbitration();
        test_frame_hold();
        test_ack_timeout();
        test_hold_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/efb_wb_arbiter.md
EFB_WB_ARBITER -- requirements
Module: efb_wb_arbiter

Interface
REQ-001 Parameter ACK_TIMEOUT, default 64, is the number of cycles a granted strobe may wait for efb_ack_i before an error.
REQ-002 Parameter HOLD_TIMEOUT, default 1024, is the number of idle cycles an open config frame may stay locked before a forced release.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mN_cyc_i, mN_stb_i, mN_we_i  input  1 each  Wishbone classic master N controls, for N = 0 and 1.
REQ-006 mN_adr_i, mN_dat_i  input  8 each  master N address and write data.
REQ-007 mN_dat_o  output  8  read data; equals efb_dat_i for both masters.
REQ-008 mN_ack_o, mN_err_o  output  1 each  master N termination.
REQ-009 efb_cyc_o, efb_stb_o, efb_we_o  output  1 each  EFB slave controls.
REQ-010 efb_adr_o, efb_dat_o  output  8 each  EFB address and write data.
REQ-011 efb_dat_i  input  8  EFB read data.
REQ-012 efb_ack_i  input  1  EFB acknowledge.
REQ-013 grant  output  2  one-hot owner; 2'b00 when idle.
REQ-014 lock_timeout  output  1  one-cycle pulse on forced release.

Function
REQ-015 The arbiter SHALL have three states: IDLE (no owner), BUSY (owner cyc high), and HOLD (owner cyc low, config frame open).
REQ-016 A master SHALL request by asserting cyc; in IDLE a request SHALL be registered as owner, giving grant one cycle after the request is sampled.
REQ-017 On simultaneous requests in IDLE, the master other than the last owner SHALL win; last owner resets to master 1, so master 0 wins first.
REQ-018 The EFB outputs SHALL be a combinational mux of the owner's signals in BUSY and all-zero in IDLE and HOLD.
REQ-019 mN_ack_o SHALL be efb_ack_i AND grant[N] AND mN_stb_i; a non-owner SHALL never see ack or err.
REQ-020 A frame SHALL open on an acked owner write to address 0x70 with data bit 7 = 1.
REQ-021 A frame SHALL close on an acked owner write to 0x70 with data bit 7 = 0.
REQ-022 In BUSY, owner cyc falling SHALL go to HOLD if a frame is open, else to IDLE.
REQ-023 In HOLD, owner cyc rising SHALL return to BUSY with the same owner; the other master's requests SHALL be ignored.
REQ-024 ACK watchdog: in BUSY with owner stb high, a counter SHALL count cycles without ack.
REQ-025 When that counter reaches ACK_TIMEOUT, mN_err_o of the owner SHALL pulse for one cycle, EFB stb SHALL be gated off that cycle, and the counter SHALL clear.
REQ-026 The ACK watchdog counter SHALL clear on any ack.
REQ-027 HOLD watchdog: a counter SHALL count HOLD cycles.
REQ-028 When that counter reaches HOLD_TIMEOUT, the arbiter SHALL clear the frame flag, go to IDLE, and pulse lock_timeout for one cycle.
REQ-029 Counters SHALL be wide enough for their parameter and SHALL saturate, not wrap.
REQ-030 If ack and a frame-close write coincide with cyc falling, the arbiter SHALL go to IDLE, not HOLD.

Reset
REQ-031 On rst the arbiter SHALL be in IDLE with grant = 0, frame flag = 0, counters = 0, last owner = 1, and lock_timeout = 0.
REQ-032 In the cycle after rst, all ack and err outputs and efb_cyc_o/stb_o/we_o SHALL be 0, even if asserted mid-transfer.

Structure
REQ-033 Shared package SHALL hold the state encodings and constants CFGCR_ADR = 8'h70 and CFG_EN_BIT = 7.
REQ-034 The arbiter SHALL be a single flat module with no sub-modules; the two watchdog counters are inline.

Verification
REQ-035 Master 0 alone writes 0x80 to 0x70 (ack after 2 cycles) -> grant = 01 one cycle after cyc; m0_ack_o pulses once; efb_dat_o = 0x80; m1_ack_o stays 0.
REQ-036 Both masters raise cyc in the same cycle after reset -> grant = 01; after m0 releases with no frame, grant returns to 00 then goes to 10.
REQ-037 m0 opens a frame (0x80 to 0x70), drops cyc for 5 cycles while m1 requests -> grant stays 01 through HOLD; m0 writes 0x00 to 0x70 and drops cyc -> IDLE, then grant = 10.
REQ-038 Owner stb held with no ack -> m0_err_o pulses exactly at cycle ACK_TIMEOUT; efb_stb_o is 0 that cycle.
REQ-039 m0 opens a frame and goes silent -> lock_timeout pulses at HOLD_TIMEOUT cycles after entering HOLD; m1 is granted on the next cycle.
REQ-040 rst asserted while BUSY with stb high -> next cycle grant = 00, efb_cyc_o = 0, and no ack is propagated.
